// File: rtl/hack_alu_seq.sv
// Registered Hack ALU with valid/ready handshake, logical shifts and an
// optional shift-add multiplier enabled by defining HACK_ALU_MUL_EN.
module hack_alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             neg
);
   localparam int SHW = $clog2(WIDTH);

`ifdef HACK_ALU_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
   typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

   state_t state, next;
   state_t start_state;
   logic accept;

   logic [WIDTH-1:0] xp, yp, r, fin;
   logic [SHW-1:0]   sh;

`ifdef HACK_ALU_MUL_EN
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc, mcand, mplier, mul_fin;
   logic             no_q;
`endif

   // operand prep and single-cycle result, straight from the live inputs
   always_comb begin
      xp = zx ? (nx ? '1 : '0) : (nx ? ~x : x);
      yp = zy ? (ny ? '1 : '0) : (ny ? ~y : y);
      sh = yp[SHW-1:0];
      case (op)
         2'b10:   r = xp << sh;
         2'b11:   r = xp >> sh;
         default: r = f ? (xp + yp) : (xp & yp);
      endcase
      fin = no ? ~r : r;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next;
   end

   always_comb begin
      next        = state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      start_state = DONE;
`ifdef HACK_ALU_MUL_EN
      if (op == 2'b01) start_state = MUL;
`endif
      case (state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid) next = start_state;
         end
`ifdef HACK_ALU_MUL_EN
         MUL: if (count == CNT_LAST) next = DONE;
`endif
         DONE: begin
            out_valid = 1'b1;
            in_ready  = rst_n & out_ready;
            if (out_ready) next = in_valid ? start_state : IDLE;
         end
         default: next = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;

`ifdef HACK_ALU_MUL_EN
   assign mul_fin = no_q ? ~acc : acc;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out  <= '0;
         zero <= 1'b0;
         neg  <= 1'b0;
`ifdef HACK_ALU_MUL_EN
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         no_q   <= 1'b0;
`endif
      end else begin
         if (accept && start_state == DONE) begin
            out  <= fin;
            zero <= (fin == '0);
            neg  <= fin[WIDTH-1];
         end
`ifdef HACK_ALU_MUL_EN
         if (accept && start_state == MUL) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= xp;
            mplier <= yp;
            no_q   <= no;
         end
         // one multiplier bit per cycle, then one cycle to publish the product
         if (state == MUL) begin
            if (count != CNT_LAST) begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
            end else begin
               out  <= mul_fin;
               zero <= (mul_fin == '0);
               neg  <= mul_fin[WIDTH-1];
            end
         end
`endif
      end
   end

endmodule
